// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory handshake bundle for the fetch stage.
//   imem_req   : fetch request (fetch stage -> memory)
//   imem_addr  : fetch address, held while imem_req=1 and imem_ready=0
//   imem_ready : imem_rdata valid this cycle (memory -> fetch stage)
//   imem_rdata : instruction word
// master = fetch controller, slave = instruction memory.
interface if_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch stage controller.
// Owns the PC, runs the request/ready handshake with instruction memory and
// drives data/we/flush of the IF/ID register. Memory wait states, ID stalls
// and redirects are absorbed so IF/ID only latches a valid instruction or a
// zero bubble.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall               : ID must hold; IF/ID must not advance
//   redirect/redirect_pc: discard younger work, continue at redirect_pc
//   imem                : instruction-memory handshake (master side)
//   if_instr, if_pc4    : IF/ID data inputs
//   ifid_we, ifid_flush : IF/ID write enable / flush
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  if_fetch_ctrl_if.master       imem,
  output logic [31:0]           if_instr,
  output logic [31:0]           if_pc4,
  output logic                  ifid_we,
  output logic                  ifid_flush
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;
  logic [31:0] r_drop_addr;
  logic [31:0] w_pc4;

  // Outputs depend on the current handshake (imem_ready same cycle), so they
  // are decoded combinationally from the registered state.
  always_comb begin
    w_pc4          = r_pc + 32'd4;
    imem.imem_req  = (r_state != S_HOLD);
    imem.imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;
    if_instr       = (r_state == S_HOLD) ? r_hold_buf : imem.imem_rdata;
    if_pc4         = w_pc4;
    ifid_we        = 1'b0;
    ifid_flush     = 1'b0;
    if (rst) begin
      imem.imem_req = 1'b0;
      ifid_we       = 1'b1;
      ifid_flush    = 1'b1;
      if_instr      = '0;
      if_pc4        = '0;
    end else if (redirect) begin
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (!stall) begin
            ifid_we    = 1'b1;
            ifid_flush = !imem.imem_ready;  // wait state -> bubble
          end
        end
        S_HOLD: begin
          ifid_we = !stall;
        end
        default: begin
          ifid_we = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_state     <= S_FETCH;
      r_hold_buf  <= '0;
      r_drop_addr <= '0;
    end else if (redirect) begin
      r_pc <= redirect_pc;
      unique case (r_state)
        S_FETCH: begin
          // An issued fetch cannot be aborted: park its address and wait it out.
          if (!imem.imem_ready) begin
            r_drop_addr <= r_pc;
            r_state     <= S_DROP;
          end
        end
        S_HOLD:  r_state <= S_FETCH;
        default: r_state <= S_DROP;
      endcase
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (imem.imem_ready) begin
            if (stall) begin
              r_hold_buf <= imem.imem_rdata;
              r_state    <= S_HOLD;
            end else begin
              r_pc <= w_pc4;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_pc    <= w_pc4;
            r_state <= S_FETCH;
          end
        end
        default: begin
          if (imem.imem_ready) r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr, if_pc4;
  logic        ifid_we, ifid_flush;

  if_fetch_ctrl_if ifc ();

  if_fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (ifc.master),
    .if_instr    (if_instr),
    .if_pc4      (if_pc4),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        chk_addr;
    logic        chk_data;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_n   = 0;

  // Architectural view of the fetch stream: next PC to deliver, an optional
  // word captured while ID was stalled, and an optional orphaned memory
  // transaction belonging to a discarded path.
  logic [31:0] m_pc = RPC;
  bit          m_held = 0;
  logic [31:0] m_held_word = '0;
  bit          m_orph = 0;
  logic [31:0] m_orph_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ ~a[15:0]};
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, exp);
    end
  endtask

  // One clock of stimulus plus the expected response for that cycle.
  task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc,
                     input logic st, input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    e.cyc = cyc_n;
    e.addr = '0; e.instr = '0; e.pc4 = '0;
    e.we = 1'b0; e.flush = 1'b0; e.req = 1'b0;
    e.chk_addr = 1'b0; e.chk_data = 1'b0;
    if (r) begin
      e.we = 1'b1; e.flush = 1'b1; e.chk_data = 1'b1;
      m_pc = RPC; m_held = 0; m_orph = 0;
    end else begin
      e.req = !m_held;
      e.addr = m_orph ? m_orph_addr : m_pc;
      e.chk_addr = e.req;
      if (rd) begin
        e.we = 1'b1; e.flush = 1'b1;
        if (!m_orph && !m_held && !rdy) begin
          m_orph = 1; m_orph_addr = m_pc;
        end
        m_held = 0;
        m_pc = rpc;
      end else if (m_orph) begin
        if (rdy) m_orph = 0;
      end else if (m_held) begin
        if (!st) begin
          e.we = 1'b1; e.chk_data = 1'b1;
          e.instr = m_held_word; e.pc4 = m_pc + 32'd4;
          m_pc = m_pc + 32'd4; m_held = 0;
        end
      end else if (rdy && !st) begin
        e.we = 1'b1; e.chk_data = 1'b1;
        e.instr = mem_word(m_pc); e.pc4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
      end else if (rdy) begin
        m_held = 1; m_held_word = mem_word(m_pc);
      end else if (!st) begin
        e.we = 1'b1; e.flush = 1'b1;
      end
    end
    rst = r; redirect = rd; redirect_pc = rpc; stall = st;
    ifc.imem_ready = rdy;
    ifc.imem_rdata = (rdy && e.req) ? mem_word(e.addr) : $urandom;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per presented cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("req", e.cyc, {31'b0, ifc.imem_req}, {31'b0, e.req});
      chk("we",  e.cyc, {31'b0, ifid_we}, {31'b0, e.we});
      if (e.we) chk("flush", e.cyc, {31'b0, ifid_flush}, {31'b0, e.flush});
      if (e.chk_addr) chk("addr", e.cyc, ifc.imem_addr, e.addr);
      if (e.chk_data) begin
        chk("instr", e.cyc, if_instr, e.instr);
        chk("pc4",   e.cyc, if_pc4, e.pc4);
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ifc.imem_ready = 1'b0; ifc.imem_rdata = '0;
    // reset, then zero-wait stream
    cyc(1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);                      // 0x3000
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);  // 0x3004 wait states -> bubbles
    cyc(0, 0, 0, 0, 1);                      // 0x3004
    cyc(0, 0, 0, 1, 1);                      // 0x3008 captured under stall
    cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 1, 0);  // HOLD
    cyc(0, 0, 0, 0, 0);                      // release: held word delivered
    cyc(0, 0, 0, 0, 1);                      // 0x300C
    cyc(0, 1, 32'h4000, 0, 0);               // redirect with 0x3010 pending
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1);  // DROP until ready
    cyc(0, 0, 0, 0, 1);                      // 0x4000
    cyc(0, 0, 0, 1, 1);                      // HOLD
    cyc(0, 1, 32'h5000, 1, 0);               // redirect beats stall
    cyc(0, 0, 0, 0, 1);                      // 0x5000
    cyc(0, 0, 0, 1, 0);                      // wait + stall: quiet
    cyc(0, 1, 32'h6000, 0, 0);               // into DROP
    cyc(0, 1, 32'h7000, 0, 1);               // redirect in DROP: stays DROP
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);                      // reset mid-DROP
    cyc(0, 0, 0, 0, 1);                      // 0x3000
    cyc(0, 1, 32'hFFFF_FFFC, 0, 1);          // wrap target
    cyc(0, 0, 0, 0, 1);                      // pc4 wraps to 0
    cyc(0, 0, 0, 0, 1);                      // 0x0000_0000
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 14) == 0), rpc,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
    end
    repeat (3) @(posedge clk);
    chk("drain", cyc_n, q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
